calc_key_seq: RTL and testbench



---
 rtl/calc_seq_pkg.sv | 37 +++
 rtl/calc_key_expand.sv | 59 +++++
 rtl/calc_key_seq.sv | 177 +++++++++++++++++
 tb/tb_calc_key_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_seq_pkg.sv
// Shared constants and types for the calc key sequencer: host opcodes,
// calc button encodings, calc arithmetic op codes and sequencer states.
package calc_seq_pkg;

  localparam logic [3:0] OPC_PUSH   = 4'd0;
  localparam logic [3:0] OPC_APPEND = 4'd1;
  localparam logic [3:0] OPC_OP     = 4'd2;
  localparam logic [3:0] OPC_CLEAR  = 4'd3;
  localparam logic [3:0] OPC_PUSH32 = 4'd4;

  localparam logic [3:0] BTN_PUSH   = 4'b0010;
  localparam logic [3:0] BTN_APPEND = 4'b0100;
  localparam logic [3:0] BTN_OP     = 4'b1000;
  localparam logic [3:0] BTN_CLEAR  = 4'b1001;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_MOD  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_SWAP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP,
    ST_RESP
  } seq_state_e;

  // Division and modulo run through calc's iterative divider and need the long gap.
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/calc_key_expand.sv
// Combinational expansion of a host command into the key at a given index:
// button/switch values, whether it needs the division gap, and whether it is the last key.
module calc_key_expand
  import calc_seq_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] val,
  input  logic [1:0]  idx,
  output logic        key_valid,
  output logic [3:0]  key_btn,
  output logic [7:0]  key_sw,
  output logic        key_div,
  output logic        key_last
);

  always_comb begin
    key_valid = 1'b0;
    key_btn   = '0;
    key_sw    = '0;
    key_div   = 1'b0;
    key_last  = 1'b1;
    case (op)
      OPC_PUSH: begin
        key_valid = 1'b1;
        key_btn   = BTN_PUSH;
        key_sw    = val[7:0];
      end
      OPC_APPEND: begin
        key_valid = 1'b1;
        key_btn   = BTN_APPEND;
        key_sw    = val[7:0];
      end
      OPC_OP: begin
        key_valid = 1'b1;
        key_btn   = BTN_OP;
        key_sw    = {5'b0, val[2:0]};
        key_div   = is_div_op(val[2:0]);
      end
      OPC_CLEAR: begin
        key_valid = 1'b1;
        key_btn   = BTN_CLEAR;
      end
      OPC_PUSH32: begin
        // Most significant byte is pushed first, then appended byte by byte.
        key_valid = 1'b1;
        key_btn   = (idx == 2'd0) ? BTN_PUSH : BTN_APPEND;
        key_last  = (idx == 2'd3);
        case (idx)
          2'd0:    key_sw = val[31:24];
          2'd1:    key_sw = val[23:16];
          2'd2:    key_sw = val[15:8];
          default: key_sw = val[7:0];
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_key_seq.sv
// Command sequencer in front of calc: turns valid/ready command words into
// single-cycle key presses separated by settle gaps, and reports per-command error status.
module calc_key_seq
  import calc_seq_pkg::*;
#(
  parameter int unsigned SETTLE     = 4,
  parameter int unsigned DIV_SETTLE = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_val,
  output logic        resp_valid,
  output logic        resp_error,
  input  logic        calc_error,
  output logic [7:0]  sw,
  output logic [3:0]  btn
);

  localparam int unsigned CNT_MAX = (SETTLE > DIV_SETTLE) ? SETTLE : DIV_SETTLE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  seq_state_e  state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] val_q, val_d;
  logic [1:0]  idx_q, idx_d;
  logic        last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        sticky_q, sticky_d;
  logic [3:0]  btn_q, btn_d;
  logic [7:0]  sw_q, sw_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;

  logic [3:0]  exp_op;
  logic [31:0] exp_val;
  logic [1:0]  exp_idx;
  logic        key_valid;
  logic [3:0]  key_btn;
  logic [7:0]  key_sw;
  logic        key_div;
  logic        key_last;
  logic        sticky_nx;

  // While idle the expander looks at the offered command so the first key
  // can be registered on the accepting edge.
  always_comb begin
    if (state_q == ST_IDLE) begin
      exp_op  = cmd_op;
      exp_val = cmd_val;
      exp_idx = '0;
    end else begin
      exp_op  = op_q;
      exp_val = val_q;
      exp_idx = idx_q;
    end
  end

  calc_key_expand u_expand (
    .op        (exp_op),
    .val       (exp_val),
    .idx       (exp_idx),
    .key_valid (key_valid),
    .key_btn   (key_btn),
    .key_sw    (key_sw),
    .key_div   (key_div),
    .key_last  (key_last)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    val_d        = val_q;
    idx_d        = idx_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    sticky_d     = sticky_q;
    btn_d        = '0;
    sw_d         = sw_q;
    cmd_ready_d  = cmd_ready_q;
    resp_valid_d = 1'b0;
    resp_error_d = resp_error_q;
    sticky_nx    = sticky_q | calc_error;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          op_d        = cmd_op;
          val_d       = cmd_val;
          idx_d       = '0;
          sticky_d    = 1'b0;
          cmd_ready_d = 1'b0;
          if (key_valid) begin
            btn_d   = key_btn;
            sw_d    = key_sw;
            state_d = ST_PRESS;
          end else begin
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end
      ST_PRESS: begin
        // Gap length and last flag belong to the key just pressed; the index
        // moves on so the expander already presents the next key during the gap.
        cnt_d   = key_div ? CNT_W'(DIV_SETTLE - 1) : CNT_W'(SETTLE - 1);
        last_d  = key_last;
        idx_d   = idx_q + 2'd1;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          sticky_d = sticky_nx;
          if (last_q) begin
            resp_valid_d = 1'b1;
            resp_error_d = sticky_nx;
            state_d      = ST_RESP;
          end else begin
            btn_d   = key_btn;
            sw_d    = key_sw;
            state_d = ST_PRESS;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        sticky_d     = 1'b0;
        resp_error_d = 1'b0;
        cmd_ready_d  = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      val_q        <= '0;
      idx_q        <= '0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      sticky_q     <= 1'b0;
      btn_q        <= '0;
      sw_q         <= '0;
      cmd_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      val_q        <= val_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      sticky_q     <= sticky_d;
      btn_q        <= btn_d;
      sw_q         <= sw_d;
      cmd_ready_q  <= cmd_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign btn        = btn_q;
  assign sw         = sw_q;

endmodule

// File: tb/tb_calc_key_seq.sv
// Scoreboard bench for calc_key_seq: a command-level model predicts every key press
// and response with its cycle; a monitor compares whatever the DUT presents.
module tb_calc_key_seq;

  localparam int unsigned SETTLE     = 4;
  localparam int unsigned DIV_SETTLE = 40;
  localparam int unsigned ERR_N      = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [31:0] cmd_val = '0;
  logic        resp_valid;
  logic        resp_error;
  logic        calc_error = 1'b0;
  logic [7:0]  sw;
  logic [3:0]  btn;

  calc_key_seq #(.SETTLE(SETTLE), .DIV_SETTLE(DIV_SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_val    (cmd_val),
    .resp_valid (resp_valid),
    .resp_error (resp_error),
    .calc_error (calc_error),
    .sw         (sw),
    .btn        (btn)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  btn;
    logic [7:0]  sw;
  } press_t;

  typedef struct {
    int unsigned cyc;
    logic        err;
  } resp_t;

  press_t      pq[$];
  resp_t       rq[$];
  bit          err_at[ERR_N];
  int unsigned cyc = 0;
  int unsigned ready_at = 0;
  int          checks = 0;
  int          errors = 0;
  logic        rst_at_edge = 1'b1;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  always @(negedge clk) calc_error = err_at[cyc % ERR_N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Command-level model: list the keys, place them on the timeline, OR the
  // calc error seen in each key's final settle cycle.
  task automatic expect_cmd(input logic [3:0] op, input logic [31:0] val,
                            input int unsigned t0, input int force_err);
    logic [3:0]  kb[$];
    logic [7:0]  ks[$];
    int unsigned kg[$];
    int unsigned t;
    int unsigned ix;
    logic        e;
    case (op)
      4'd0: begin kb.push_back(4'b0010); ks.push_back(val[7:0]); kg.push_back(SETTLE); end
      4'd1: begin kb.push_back(4'b0100); ks.push_back(val[7:0]); kg.push_back(SETTLE); end
      4'd2: begin
        kb.push_back(4'b1000);
        ks.push_back({5'b0, val[2:0]});
        kg.push_back((val[2:0] == 3'd3 || val[2:0] == 3'd4) ? DIV_SETTLE : SETTLE);
      end
      4'd3: begin kb.push_back(4'b1001); ks.push_back(8'h00); kg.push_back(SETTLE); end
      4'd4: begin
        for (int k = 0; k < 4; k++) begin
          kb.push_back(k == 0 ? 4'b0010 : 4'b0100);
          ks.push_back(8'((val >> (8 * (3 - k))) & 32'hFF));
          kg.push_back(SETTLE);
        end
      end
      default: ;
    endcase
    if (kb.size() == 0) begin
      rq.push_back('{cyc: t0 + 1, err: 1'b1});
      ready_at = t0 + 2;
    end else begin
      t = t0 + 1;
      e = 1'b0;
      for (int k = 0; k < kb.size(); k++) begin
        pq.push_back('{cyc: t, btn: kb[k], sw: ks[k]});
        ix = (t + kg[k]) % ERR_N;
        if (force_err >= 0) err_at[ix] = (force_err != 0);
        e = e | err_at[ix];
        t = t + kg[k] + 1;
      end
      rq.push_back('{cyc: t, err: e});
      ready_at = t + 1;
    end
  endtask

  // Busy cycles carry random offers that must be ignored.
  task automatic wait_ready();
    while (cyc < ready_at) begin
      if (cyc + 1 == ready_at) chk("ready_low_before_free", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 4'($urandom);
      cmd_val   = $urandom;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("ready_high", 32'(cmd_ready), 32'd1);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk("ready_idle", 32'(cmd_ready), 32'd1);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] val, input int force_err);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_val   = val;
    expect_cmd(op, val, cyc, force_err);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  logic [7:0] exp_sw = '0;
  logic [3:0] prev_btn = '0;

  always @(negedge clk) begin
    press_t p;
    resp_t  r;
    if (rst_at_edge) exp_sw = '0;
    if (btn !== 4'b0) begin
      chk("btn_after_zero", 32'(prev_btn), 32'd0);
      if (pq.size() == 0) begin
        chk("unexpected_press", 32'(btn), 32'd0);
      end else begin
        p = pq.pop_front();
        chk("press_cycle", cyc, p.cyc);
        chk("press_btn", 32'(btn), 32'(p.btn));
        exp_sw = p.sw;
      end
    end else if (pq.size() > 0 && pq[0].cyc <= cyc) begin
      p = pq.pop_front();
      chk("missing_press", 32'(btn), 32'(p.btn));
    end
    chk("sw_value", 32'(sw), 32'(exp_sw));
    if (resp_valid === 1'b1) begin
      if (rq.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        r = rq.pop_front();
        chk("resp_cycle", cyc, r.cyc);
        chk("resp_error", 32'(resp_error), 32'(r.err));
      end
    end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
      r = rq.pop_front();
      chk("missing_resp", 32'(resp_valid), 32'd1);
    end
    prev_btn = btn;
  end

  initial begin
    int unsigned t0;
    logic [31:0] v;
    for (int i = 0; i < int'(ERR_N); i++) err_at[i] = ($urandom_range(0, 11) == 0);

    repeat (3) @(negedge clk);
    chk("reset_btn", 32'(btn), 32'd0);
    chk("reset_sw", 32'(sw), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_error", 32'(resp_error), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    ready_at = cyc + 1;

    issue(4'd0, 32'h12, 0);
    issue(4'd4, 32'hDEADBEEF, 0);
    issue(4'd2, 32'd0, 1);
    issue(4'd0, 32'd100, 0);
    issue(4'd0, 32'd7, 0);
    issue(4'd2, 32'd4, 0);
    issue(4'd0, 32'd5, 0);
    issue(4'd2, 32'd3, 1);
    issue(4'd0, 32'd9, 0);
    issue(4'd9, $urandom, -1);
    issue(4'd15, $urandom, -1);

    // Reset while the second PUSH32 key is on btn.
    wait_ready();
    v = $urandom;
    t0 = cyc;
    cmd_valid = 1'b1;
    cmd_op    = 4'd4;
    cmd_val   = v;
    pq.push_back('{cyc: t0 + 1, btn: 4'b0010, sw: v[31:24]});
    pq.push_back('{cyc: t0 + 2 + SETTLE, btn: 4'b0100, sw: v[23:16]});
    @(negedge clk);
    cmd_valid = 1'b0;
    while (cyc < t0 + 2 + SETTLE) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_btn", 32'(btn), 32'd0);
    chk("rst_mid_ready", 32'(cmd_ready), 32'd0);
    ready_at = cyc + 1;

    for (int n = 0; n < 50; n++) begin
      int unsigned r;
      logic [3:0]  op;
      r = $urandom_range(0, 9);
      v = $urandom;
      case (r)
        0, 1:    op = 4'd0;
        2:       op = 4'd1;
        3, 4, 5: op = 4'd2;
        6:       op = 4'd3;
        7, 8:    op = 4'd4;
        default: op = 4'($urandom_range(5, 15));
      endcase
      issue(op, v, -1);
    end

    for (int i = 0; i < 300 && (pq.size() != 0 || rq.size() != 0); i++) @(negedge clk);
    chk("drain_outstanding", 32'(pq.size() + rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
